// File: rtl/alu_seq_pkg.sv
// Shared types and ALU command encodings for the multi-byte ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_NAND = 3'b100
  } op_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_LSH  = 3'b001;
  localparam logic [2:0] ALU_RSH  = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] o);
    return (o <= 3'b100);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Multi-byte sequencer driving an 8-bit combinational ALU one byte per cycle,
// chaining the ALU carry/shift-out back into its carry/shift-in.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  fill,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  zero,
  output logic                  parity,
  output logic [2:0]            alu_cmd,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_sci,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sco
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  state_t         state, state_nxt;
  logic [IW-1:0]  idx;
  op_t            op_q;
  logic [W-1:0]   a_q, b_q;
  logic           fill_q;
  logic           carry_q;
  logic           first_byte, last_byte;
  logic [7:0]     a_byte, b_byte;
  logic [W-1:0]   result_nxt;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // SHR walks the bytes downward, every other op walks upward
  always_comb begin
    first_byte = 1'b0;
    last_byte  = 1'b0;
    if (op_q == OP_SHR) begin
      first_byte = (idx == IDX_LAST);
      last_byte  = (idx == '0);
    end else begin
      first_byte = (idx == '0);
      last_byte  = (idx == IDX_LAST);
    end
  end

  always_comb begin
    a_byte     = '0;
    b_byte     = '0;
    result_nxt = result;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (IW'(i) == idx) begin
        a_byte                = a_q[8*i +: 8];
        b_byte                = b_q[8*i +: 8];
        result_nxt[8*i +: 8]  = alu_rslt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op_legal(op) ? EXEC : DONE;
      EXEC:    if (last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_cmd = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    alu_sci = 1'b0;
    if (state == EXEC) begin
      case (op_q)
        OP_ADD: begin
          alu_cmd = ALU_ADD;
          alu_a   = a_byte;
          alu_b   = b_byte;
          alu_sci = first_byte ? 1'b0 : carry_q;
        end
        OP_SUB: begin
          alu_cmd = ALU_ADD;
          alu_a   = a_byte;
          alu_b   = ~b_byte;
          alu_sci = first_byte ? 1'b1 : carry_q;
        end
        OP_SHL: begin
          alu_cmd = ALU_LSH;
          alu_a   = a_byte;
          alu_sci = first_byte ? fill_q : carry_q;
        end
        OP_SHR: begin
          alu_cmd = ALU_RSH;
          alu_a   = a_byte;
          alu_sci = first_byte ? fill_q : carry_q;
        end
        OP_NAND: begin
          alu_cmd = ALU_NAND;
          alu_a   = a_byte;
          alu_b   = b_byte;
        end
        default: ;
      endcase
    end
  end

  // zero/parity are taken from the completed result on the final byte edge
  // so they are already valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      fill_q    <= 1'b0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result    <= '0;
            carry_out <= 1'b0;
            parity    <= 1'b0;
            carry_q   <= 1'b0;
            if (op_legal(op)) begin
              op_q   <= op_t'(op);
              a_q    <= a;
              b_q    <= b;
              fill_q <= fill;
              idx    <= (op == OP_SHR) ? IDX_LAST : '0;
              err    <= 1'b0;
              zero   <= 1'b0;
            end else begin
              err  <= 1'b1;
              zero <= 1'b1;
            end
          end
        end
        EXEC: begin
          result  <= result_nxt;
          carry_q <= alu_sco;
          idx     <= (op_q == OP_SHR) ? idx - IW'(1) : idx + IW'(1);
          if (last_byte) begin
            idx       <= '0;
            carry_out <= (op_q == OP_NAND) ? 1'b0 : alu_sco;
            zero      <= (result_nxt == '0);
            parity    <= ^result_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural 8-bit ALU responder and
// a word-level reference model.
module tb_alu_seq;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          fill = 1'b0;
  logic          busy, done, err, carry_out, zero, parity;
  logic [W-1:0]  result;
  logic [2:0]    alu_cmd;
  logic [7:0]    alu_a, alu_b, alu_rslt;
  logic          alu_sci, alu_sco;

  int tests = 0;
  int fails = 0;

  alu_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .fill(fill),
    .busy(busy), .done(done), .err(err), .result(result), .carry_out(carry_out),
    .zero(zero), .parity(parity), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sci(alu_sci), .alu_rslt(alu_rslt), .alu_sco(alu_sco)
  );

  always #5 clk = ~clk;

  // Combinational 8-bit ALU responder
  always_comb begin
    alu_rslt = '0;
    alu_sco  = 1'b0;
    case (alu_cmd)
      3'b000: {alu_sco, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sci};
      3'b001: {alu_sco, alu_rslt} = {alu_a, alu_sci};
      3'b010: {alu_rslt, alu_sco} = {alu_sci, alu_a};
      3'b011: alu_rslt = ~(alu_a & alu_b);
      3'b100: {alu_sco, alu_rslt} = {1'b0, alu_a} - {1'b0, alu_b};
      default: ;
    endcase
  end

  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] av, bv,
                                    input logic f, output logic [W-1:0] r,
                                    output logic c, output logic e);
    logic [W:0] wide;
    r = '0; c = 1'b0; e = 1'b0;
    case (o)
      3'd0: begin wide = {1'b0, av} + {1'b0, bv}; r = wide[W-1:0]; c = wide[W]; end
      3'd1: begin wide = {1'b0, av} + {1'b0, ~bv} + 1; r = wide[W-1:0]; c = wide[W]; end
      3'd2: begin r = {av[W-2:0], f}; c = av[W-1]; end
      3'd3: begin r = {f, av[W-1:1]}; c = av[0]; end
      3'd4: r = ~(av & bv);
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one op when the DUT is idle; returns cycles from accept to done
  // (capped at 20) plus the ALU drive seen in the first cycle.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, bv, input logic f,
                       output int lat, output logic [2:0] cmd1, output logic [7:0] a1);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    start = 1'b1; op = o; a = av; b = bv; fill = f;
    @(posedge clk); #1;
    start = 1'b0;
    cmd1 = alu_cmd; a1 = alu_a;
    lat = 1;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    tests++;
    if ({busy, done, err, carry_out, zero, parity, alu_sci} !== 7'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 0", {busy, done, err, carry_out, zero, parity, alu_sci});
    end
    tests++;
    if ({result, alu_cmd, alu_a, alu_b} !== '0) begin
      fails++; $display("FAIL reset_data: got %h expected 0", {result, alu_cmd, alu_a, alu_b});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [7:0] bz, dn;
    bz = '0; dn = '0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 16'h12FF; b = 16'h0001; fill = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bz[c] = busy; dn[c] = done;
      if (c == 3) begin
        tests++;
        if (result !== 16'h1300 || carry_out !== 1'b0 || zero !== 1'b0) begin
          fails++; $display("FAIL add_result: got %h c%b z%b expected 1300 c0 z0", result, carry_out, zero);
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (bz[4:1] !== 4'b0111) begin fails++; $display("FAIL add_busy: got %b expected 0111", bz[4:1]); end
    tests++;
    if (dn[4:1] !== 4'b0100) begin fails++; $display("FAIL add_done: got %b expected 0100", dn[4:1]); end
  endtask

  task automatic test_sub;
    int lat; logic [2:0] c1; logic [7:0] a1;
    do_op(3'd1, 16'h1000, 16'h0001, 1'b0, lat, c1, a1);
    tests++;
    if (result !== 16'h0FFF || carry_out !== 1'b1 || lat != 3) begin
      fails++; $display("FAIL sub_noborrow: got %h c%b lat%0d expected 0fff c1 lat3", result, carry_out, lat);
    end
    do_op(3'd1, 16'h0000, 16'h0001, 1'b0, lat, c1, a1);
    tests++;
    if (result !== 16'hFFFF || carry_out !== 1'b0 || parity !== 1'b0) begin
      fails++; $display("FAIL sub_borrow: got %h c%b p%b expected ffff c0 p0", result, carry_out, parity);
    end
  endtask

  task automatic test_shift;
    int lat; logic [2:0] c1; logic [7:0] a1;
    do_op(3'd2, 16'h8081, 16'h0000, 1'b0, lat, c1, a1);
    tests++;
    if (result !== 16'h0102 || carry_out !== 1'b1) begin
      fails++; $display("FAIL shl: got %h c%b expected 0102 c1", result, carry_out);
    end
    do_op(3'd3, 16'h0101, 16'h0000, 1'b1, lat, c1, a1);
    tests++;
    if (result !== 16'h8080 || carry_out !== 1'b1) begin
      fails++; $display("FAIL shr: got %h c%b expected 8080 c1", result, carry_out);
    end
    do_op(3'd3, 16'h5A01, 16'h0000, 1'b0, lat, c1, a1);
    tests++;
    if (c1 !== 3'b010 || a1 !== 8'h5A) begin
      fails++; $display("FAIL shr_msb_first: got cmd %b a %h expected 010 5a", c1, a1);
    end
  endtask

  task automatic test_nand;
    int lat; logic [2:0] c1; logic [7:0] a1;
    do_op(3'd4, 16'hFFFF, 16'hFFFF, 1'b0, lat, c1, a1);
    tests++;
    if (result !== 16'h0000 || zero !== 1'b1 || parity !== 1'b0 || carry_out !== 1'b0) begin
      fails++; $display("FAIL nand: got %h z%b p%b c%b expected 0000 z1 p0 c0", result, zero, parity, carry_out);
    end
  endtask

  task automatic test_illegal_and_ignore;
    int lat; logic [2:0] c1; logic [7:0] a1;
    do_op(3'd7, 16'h1234, 16'h5678, 1'b0, lat, c1, a1);
    tests++;
    if (lat != 1 || err !== 1'b1 || result !== 16'h0000) begin
      fails++; $display("FAIL illegal: got lat%0d err%b %h expected lat1 err1 0000", lat, err, result);
    end
    // second start pulse during EXEC must be ignored
    @(negedge clk); @(negedge clk);
    start = 1'b1; op = 3'd0; a = 16'h0102; b = 16'h0304;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 16'hAAAA; b = 16'h5555;
    @(posedge clk); #1; start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    tests++;
    if (result !== 16'h0406 || lat != 3 || err !== 1'b0) begin
      fails++; $display("FAIL start_in_exec: got %h lat%0d err%b expected 0406 lat3 err0", result, lat, err);
    end
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (busy !== 1'b0 || result !== 16'h0406) begin
      fails++; $display("FAIL start_in_exec_after: got busy%b %h expected busy0 0406", busy, result);
    end
  endtask

  task automatic test_reset_mid_exec;
    int lat; logic [2:0] c1; logic [7:0] a1;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 16'h1234; b = 16'h1111;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    tests++;
    if ({busy, done, err, carry_out, zero, parity, alu_sci} !== 7'b0 || result !== '0) begin
      fails++; $display("FAIL reset_mid_flags: got %b %h expected 0", {busy, done, err, carry_out, zero, parity, alu_sci}, result);
    end
    tests++;
    if ({alu_cmd, alu_a, alu_b} !== '0) begin
      fails++; $display("FAIL reset_mid_alu: got %h expected 0", {alu_cmd, alu_a, alu_b});
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(3'd0, 16'h0001, 16'h0001, 1'b0, lat, c1, a1);
    tests++;
    if (result !== 16'h0002 || lat != 3) begin
      fails++; $display("FAIL after_reset_add: got %h lat%0d expected 0002 lat3", result, lat);
    end
  endtask

  task automatic test_random;
    int lat; logic [2:0] c1; logic [7:0] a1;
    logic [2:0] o; logic [W-1:0] av, bv, er; logic f, ec, ee;
    for (int n = 0; n < 60; n++) begin
      o = 3'($urandom_range(0, 7));
      av = W'($urandom); bv = W'($urandom); f = 1'($urandom);
      if (n % 10 == 0) av = '0;
      ref_model(o, av, bv, f, er, ec, ee);
      do_op(o, av, bv, f, lat, c1, a1);
      tests++;
      if (result !== er || carry_out !== ec || err !== ee || zero !== (er == '0) ||
          parity !== ^er || lat != (ee ? 1 : NB + 1)) begin
        fails++;
        $display("FAIL random op%0d a=%h b=%h f=%b: got %h c%b e%b z%b p%b lat%0d expected %h c%b e%b z%b p%b lat%0d",
                 o, av, bv, f, result, carry_out, err, zero, parity, lat,
                 er, ec, ee, (er == '0), ^er, (ee ? 1 : NB + 1));
      end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_add;
    test_sub;
    test_shift;
    test_nand;
    test_illegal_and_ignore;
    test_reset_mid_exec;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
